// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I definitions for the instruction encoder:
//   imm_sel_t  - immediate format selector (I, S, B, U, J; codes 5-7 reserved)
//   OP_*       - base opcode constants
//   NOP_WORD   - canonical NOP (addi x0, x0, 0) used as the error substitute
// ---------------------------------------------------------------------------
package rv32i_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_OP_IMM = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imm_pack.sv
// ---------------------------------------------------------------------------
// imm_pack
// Combinational inverse of ImmGen: places the immediate and register fields
// into their bit positions for the selected format and flags immediates that
// the format cannot represent.
// Ports:
//   imm_sel  in  3   format selector (imm_sel_t encoding, 5-7 reserved)
//   opcode   in  7   opcode field
//   funct3   in  3   funct3 field
//   rd/rs1/rs2 in 5  register fields (unused ones ignored per format)
//   imm      in  32  signed immediate
//   instr    out 32  packed word (raw; NOP substitution happens downstream)
//   err      out 1   immediate out of range / misaligned / reserved format
// ---------------------------------------------------------------------------
module imm_pack
  import rv32i_pkg::*;
(
  input  logic [2:0]  imm_sel,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // A value fits an N-bit signed field when all bits from N-1 upward agree.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (imm_sel_t'(imm_sel))
      IMM_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits12;
      end
      IMM_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !fits12;
      end
      IMM_B: begin
        // Even offsets only, so the 13-bit range tops out at 4094.
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !fits13 || imm[0];
      end
      IMM_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = |imm[11:0];
      end
      IMM_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !fits21 || imm[0];
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Two-stage valid/ready pipeline around imm_pack. Stage 1 captures the
// request (fields already placed by imm_pack) together with its range-check
// verdict; stage 2 holds the delivered word, substituting a NOP for errored
// requests. Both stages advance together whenever the output is free or being
// taken, so a full pipe streams one word per cycle.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready = advance, low in reset)
//   imm_sel, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm  request
//   out_valid/out_ready  result handshake
//   out_instr, out_err   encoded word / word is substituted NOP
//   err_count            saturating count of errored words delivered
// ---------------------------------------------------------------------------
module instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       imm_sel,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  logic        advance;
  logic [31:0] pack_word;
  logic        pack_err;

  logic        s1_valid;
  logic [31:0] s1_word;
  logic        s1_err;

  // Whole pipe moves when the output slot is empty or is being consumed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  imm_pack u_imm_pack (
    .imm_sel (imm_sel),
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .instr   (pack_word),
    .err     (pack_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_word   <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (advance) begin
      // Valid bits move independently of the payload, so a bubble in stage 1
      // simply empties stage 2 while the previous word drains.
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (in_valid) begin
        s1_word <= pack_word;
        s1_err  <= pack_err;
      end
      if (s1_valid) begin
        out_instr <= s1_err ? NOP_WORD : s1_word;
        out_err   <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && !(&err_count)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Directed literal cases followed by randomized traffic. A queue-based model
// computes every expected word from the format rules with plain arithmetic;
// one negedge process compares the DUT against it each cycle.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  typedef struct {
    logic [31:0] w;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  imm_sel = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  // Narrow-counter instance for the saturation case.
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [31:0] b_out_instr;
  logic        b_out_err;
  logic [1:0]  b_err_count;

  int n_checks = 0;
  int n_fail = 0;
  int n_delivered = 0;
  int model_cnt = 0;
  exp_t exp_q[$];
  bit prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  always #5 clk = ~clk;

  instr_encoder #(.ERR_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  instr_encoder #(.ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .imm_sel(3'd7), .in_opcode(7'h13), .in_funct3(3'd0),
    .in_rd(5'd1), .in_rs1(5'd2), .in_rs2(5'd3), .in_imm(32'd5),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_instr(b_out_instr),
    .out_err(b_out_err), .err_count(b_err_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (bound expired or unexpected event) t=%0t", name, $time);
  endtask

  // Reference encoding computed from the format definitions.
  function automatic exp_t model(input logic [2:0] sel, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    exp_t r;
    int v;
    logic [31:0] regs;
    bit bad;
    v = int'($signed(imm));
    bad = 1'b0;
    r.w = 32'h0;
    case (sel)
      3'd0: begin
        bad = (v < -2048) || (v > 2047);
        regs = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
        r.w = ((imm & 32'hFFF) << 20) | regs;
      end
      3'd1: begin
        bad = (v < -2048) || (v > 2047);
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        r.w = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7) | regs;
      end
      3'd2: begin
        bad = (v < -4096) || (v > 4094) || ((v % 2) != 0);
        regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        r.w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
            | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | regs;
      end
      3'd3: begin
        bad = (imm & 32'hFFF) != 0;
        r.w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      end
      3'd4: begin
        bad = (v < -1048576) || (v > 1048574) || ((v % 2) != 0);
        r.w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
            | (32'(rd) << 7) | 32'(op);
      end
      default: bad = 1'b1;
    endcase
    if (bad) r.w = 32'h0000_0013;
    r.e = bad;
    return r;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_err", out_err, 0);
      check("rst_err_count", err_count, 0);
      exp_q.delete();
      model_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, 32'(!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_instr", out_instr, prev_instr);
        check("stall_err", out_err, prev_err);
      end
      check("err_count", err_count, model_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          check("word", out_instr, exp_q[0].w);
          check("word_err", out_err, exp_q[0].e);
          if (out_ready) begin
            if (exp_q[0].e && model_cnt != 65535) model_cnt++;
            void'(exp_q.pop_front());
            n_delivered++;
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(imm_sel, in_opcode, in_funct3, in_rd, in_rs1, in_rs2, in_imm));
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err = out_err;
    end
  end

  task automatic rand_inputs();
    int edges[16];
    int c;
    edges = '{-2048, -2049, 2047, 2048, -4096, -4097, -4098, 4094,
              4095, 4096, -1048576, -1048578, 1048574, 1048575, 1048576, 0};
    imm_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    in_opcode = 7'($urandom);
    in_funct3 = 3'($urandom);
    in_rd = 5'($urandom);
    in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom);
    c = $urandom_range(0, 4);
    case (c)
      0: in_imm = 32'(edges[$urandom_range(0, 15)]);
      1: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: in_imm = $urandom & 32'hFFFF_F000;
      3: in_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      default: in_imm = $urandom;
    endcase
  endtask

  task automatic directed(input string name, input logic [2:0] sel, input logic [6:0] op,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_w, input logic exp_e);
    int n;
    bit got;
    imm_sel = sel; in_opcode = op; in_funct3 = f3;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    out_ready = 1'b1;
    in_valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      fail_now({name, "_accept"});
    end else begin
      got = 1'b0;
      n = 0;
      while (!got && n < 10) begin
        @(negedge clk);
        n++;
        if (out_valid) got = 1'b1;
      end
      if (!got) fail_now({name, "_out_valid"});
      else begin
        check({name, "_latency"}, n, 2);
        check({name, "_instr"}, out_instr, exp_w);
        check({name, "_err"}, out_err, exp_e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || out_valid) fail_now({name, "_drain"});
  endtask

  initial begin
    int accepted;
    int cyc;
    int start_deliv;
    logic [2:0] err_sels[3];
    logic [31:0] err_imms[3];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_err_count", err_count, 0);
    check("reset_out_instr", out_instr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Hand-encoded reference instructions.
    directed("lw",  3'd0, 7'h03, 3'd2, 5'd6, 5'd9, 5'd0, -32'sd4,  32'hFFC4A303, 1'b0);
    directed("sw",  3'd1, 7'h23, 3'd2, 5'd0, 5'd9, 5'd6, 32'd8,    32'h0064A423, 1'b0);
    directed("beq", 3'd2, 7'h63, 3'd0, 5'd0, 5'd4, 5'd4, -32'sd12, 32'hFE420AE3, 1'b0);
    directed("lui", 3'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
    directed("jal", 3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0);

    // Three errored requests back to back.
    err_sels = '{3'd2, 3'd0, 3'd6};
    err_imms = '{32'd3, 32'd2048, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imm_sel = err_sels[i]; in_imm = err_imms[i];
      in_opcode = 7'h13; in_funct3 = 3'd1; in_rd = 5'd7; in_rs1 = 5'd8; in_rs2 = 5'd9;
      in_valid = 1'b1;
      @(negedge clk);
      check("err_burst_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("err_burst_word", out_instr, 32'h00000013);
    check("err_burst_flag", out_err, 1);
    repeat (4) @(posedge clk);
    #1;
    check("err_burst_count", err_count, 3);

    // Saturation with a 2-bit counter.
    b_in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_count_mid", b_err_count, 3);
    repeat (3) @(posedge clk);
    #1;
    check("sat_count_final", b_err_count, 3);

    // Eight-word stream with output stalled in cycles 3-5.
    start_deliv = n_delivered;
    accepted = 0;
    cyc = 0;
    while (accepted < 8 && cyc < 40) begin
      rand_inputs();
      in_valid = 1'b1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      @(negedge clk);
      if (cyc >= 3 && cyc <= 5) check("stream_in_ready_low", in_ready, 0);
      if (in_valid && in_ready) accepted++;
      @(posedge clk); #1;
      cyc++;
    end
    drain("stream");
    check("stream_count", n_delivered - start_deliv, 8);

    // Reset with two words in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("inflight_present", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_err_count", err_count, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_delivery_after_reset", out_valid, 0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ERR_W, default 16, width of the error counter.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present; in_ready  output  1  request accepted this cycle when both high.
REQ-005 imm_sel  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J; 5-7 reserved.
REQ-006 in_opcode  input  7; in_funct3  input  3; in_rd, in_rs1, in_rs2  input  5 each; instruction fields.
REQ-007 in_imm  input  32  signed immediate value as ImmGen would produce it (U: full value, low 12 bits expected zero).
REQ-008 out_valid  output  1; out_ready  input  1; out_instr  output  32  encoded word; out_err  output  1  word is substituted NOP.
REQ-009 err_count  output  ERR_W  saturating count of errored words delivered.

Function
REQ-010 SHALL be the inverse of ImmGen: pack in_imm into instruction fields per imm_sel.
REQ-011 Packing: I: imm[11:0],rs1,f3,rd,op; S: imm[11:5],rs2,rs1,f3,imm[4:0],op; B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op; U: imm[31:12],rd,op; J: imm[20],imm[10:1],imm[11],imm[19:12],rd,op.
REQ-012 Fields unused by a format (rs2 for I/U/J, rd for S/B, etc.) SHALL be ignored.
REQ-013 Range check: I/S in [-2048,2047]; B in [-4096,4094] and imm[0]=0; U imm[11:0]=0; J in [-1048576,1048574] and imm[0]=0; imm_sel 5-7 always error.
REQ-014 On range error out_instr SHALL be 32'h00000013 and out_err=1; otherwise out_err=0.
REQ-015 Two-stage pipeline: stage 1 registers fields and range-check result; stage 2 registers packed word.
REQ-016 Latency: accepted request appears on out_valid exactly 2 cycles later with no backpressure; throughput 1 word/cycle.
REQ-017 Pipeline advance enable = !out_valid || out_ready; in_ready SHALL equal this enable (combinational from out_ready).
REQ-018 When stalled (out_valid && !out_ready) all stage registers, out_instr, out_err SHALL hold stable.
REQ-019 Bubbles: stage valid bits SHALL propagate independently; a bubble in stage 1 does not block stage 2 draining.
REQ-020 err_count SHALL increment on out_valid && out_ready && out_err, saturating at all-ones.
REQ-021 Simultaneous accept and deliver in one cycle SHALL both take effect (full-throughput flow).

Reset
REQ-022 While rst high: in_ready=0, out_valid=0, out_instr=0, out_err=0, err_count=0, stage valids cleared.
REQ-023 Reset mid-operation SHALL discard in-flight words; none are delivered after reset release.
REQ-024 in_ready SHALL rise the first cycle after rst deasserts.

Structure
REQ-025 Shared package rv32i_pkg SHALL hold imm_sel enumeration (I,S,B,U,J), opcode constants, and NOP word constant.
REQ-026 Combinational sub-module imm_pack SHALL hold field packing and range check; instr_encoder holds pipeline, handshake and counter.

Verification
REQ-027 lw x6,-4(x9): sel=0, op=0x03, f3=2, rd=6, rs1=9, imm=-4 -> out_instr=FFC4A303, out_err=0, 2 cycles after accept.
REQ-028 sw x6,8(x9): sel=1, op=0x23, f3=2, rs1=9, rs2=6, imm=8 -> 0064A423; beq x4,x4,-12: sel=2, op=0x63, f3=0 -> FE420AE3.
REQ-029 B imm=3 (odd), I imm=2048, sel=6 back-to-back -> three words 00000013, out_err=1 each, err_count=3.
REQ-030 Stream 8 words with out_ready low cycles 3-5 -> in_ready low same cycles, out_instr stable, order preserved, none lost or duplicated.
REQ-031 Assert rst with two words in flight -> out_valid=0 next edge, err_count=0, no delivery after release.
REQ-032 ERR_W=2, deliver 5 errored words -> err_count stops at 3.
